sp_dma_engine: RTL and testbench
================================

# sp_dma_engine

Block-copy DMA engine for the SP processor: on a command it copies `cmd_len` 32-bit words from SRAM address `cmd_src` to `cmd_dst`, ascending. It sits beside CTL on the shared single-port SRAM. It issues requests that CTL arbitrates: CTL grants idle SRAM cycles and muxes the engine's address, data, EN and WE onto `sram_*`. CTL launches it from a DMA instruction and polls `busy`/`remaining` for its status instruction.

## Interface
- `ADDR_W`, 16, SRAM word-address width (matches `sram_ADDR`)
- `DATA_W`, 32, SRAM data width (matches `sram_DI`/`sram_DO`)
- `clk`  in  1  sole clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high; one clock; single clock domain.
- `cmd_valid`  in  1  command strobe; accepted when `cmd_valid && cmd_ready`.
- `cmd_ready`  out  1  high in IDLE only.
- `cmd_src`  in  ADDR_W  source start address.
- `cmd_dst`  in  ADDR_W  destination start address.
- `cmd_len`  in  ADDR_W  word count; 0 is legal.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  one-cycle pulse when the copy completes.
- `remaining`  out  ADDR_W  words not yet written.
- `mem_req`  out  1  engine requests the SRAM this cycle.
- `mem_gnt`  in  1  CTL grant; an access is issued in a cycle where `mem_req && mem_gnt`.
- `mem_addr`  out  ADDR_W  access address.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_di`  out  DATA_W  write data.
- `mem_do`  in  DATA_W  SRAM read data, valid the cycle after a granted read.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - `cmd_ready=1`, `mem_req=0`.
  - On accept, latch src/dst pointers and `remaining=cmd_len`.
  - Go to DONE if `cmd_len==0`, otherwise go to READ.
- READ:
  - `mem_req=1`, `mem_we=0`, `mem_addr=src_ptr`.
  - On grant: `src_ptr+=1`, set `rd_pending`, go to WRITE.
  - Without grant, hold every output.
- WRITE:
  - `mem_req=1`, `mem_we=1`, `mem_addr=dst_ptr`.
  - `mem_di = rd_pending ? mem_do : data_buf`.
  - On the first WRITE cycle (`rd_pending=1`), `data_buf` loads `mem_do` and `rd_pending` clears. Read data therefore survives any number of ungranted cycles.
  - On grant: `dst_ptr+=1`, `remaining-=1`. Go to DONE if `remaining` was 1, otherwise go to READ.
- DONE: `done=1` for one cycle, `busy=0`, then IDLE.
- Pointer arithmetic is modulo 2^ADDR_W: 0xFFFF+1 wraps to 0x0000 silently.
- Overlapping ranges are copied strictly word-by-word, ascending: read i, then write i, then read i+1. If dst > src with overlap, the source pattern replicates. This is the defined behaviour.
- `cmd_valid` outside IDLE is ignored. There is no queueing and no error flag.
- `mem_req` is only asserted in READ or WRITE. `mem_we` and `mem_di` are don't-care when `mem_req=0`, but are driven to 0.

## Timing
- Reset values: state IDLE, `cmd_ready=1`, `busy=0`, `done=0`, `remaining=0`, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_di=0`, `rd_pending=0`, `data_buf=0`.
- Reset asserted mid-copy aborts on that edge and returns to the reset values. Words already written stay written. No `done` pulse.
- With `mem_gnt` held at 1 and acceptance at cycle 0:
  - read of word i is granted at cycle 1+2i;
  - write of word i is granted at cycle 2+2i;
  - `done` is high at cycle 2N+1;
  - `cmd_ready` is high again at cycle 2N+2.
- `cmd_len=0`: `done` at cycle 1, no memory access.
- Throughput: 2 cycles per word at full grant. Each ungranted cycle adds exactly one cycle.
- `remaining` decrements in the cycle after each granted write.

## Structure
- Shared package `sp_pkg` holds:
  - `ADDR_W`/`DATA_W` constants, shared with SRAM/CTL;
  - the `dma_state_t` enum (IDLE, READ, WRITE, DONE);
  - the DMA opcode constants CTL decodes.
- Single module with no sub-modules. Arbitration and SRAM muxing stay in CTL.

## Test plan
- `gnt=1`, src=0x0010, dst=0x0100, len=4, SRAM[0x10..0x13]=0xA0..0xA3:
  - SRAM[0x100..0x103]=0xA0..0xA3;
  - `done` at cycle 9;
  - `remaining` steps 4→0.
- len=0 -> `done` at cycle 1, `mem_req` never high, SRAM unchanged.
- Same copy with `gnt` toggling 1,0,0,1,…:
  - data is correct;
  - `mem_addr`, `mem_we` and `mem_di` are stable through stalls;
  - the 2-cycle stall right after a read still writes the captured word.
- src=0xFFFE, dst=0x0020, len=4 -> reads 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap) into 0x20..0x23.
- Overlap src=0x40, dst=0x41, len=3, SRAM[0x40]=0x5 -> SRAM[0x41..0x43]=0x5.
- Reset and ignored commands:
  - `reset` pulsed after the second write -> only 2 words copied, all outputs at reset values the next cycle, no `done`;
  - a `cmd_valid` during `busy` is ignored.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared SP processor definitions: SRAM geometry, DMA engine states and the
// DMA opcodes that CTL decodes.
package sp_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_t;

    // CTL launches a copy with OP_DMA_START and polls busy/remaining with OP_DMA_STATUS.
    localparam logic [3:0] OP_DMA_START  = 4'hC;
    localparam logic [3:0] OP_DMA_STATUS = 4'hD;

endpackage

// File: rtl/sp_dma_engine.sv
// Block-copy DMA engine: copies cmd_len words from cmd_src to cmd_dst, ascending,
// one read then one write per word through CTL-arbitrated SRAM requests.
module sp_dma_engine #(
    parameter int ADDR_W = sp_pkg::ADDR_W,
    parameter int DATA_W = sp_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] remaining,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_di,
    input  logic [DATA_W-1:0] mem_do
);
    import sp_pkg::*;

    dma_state_t        state, state_next;
    logic [ADDR_W-1:0] src_ptr, src_next;
    logic [ADDR_W-1:0] dst_ptr, dst_next;
    logic [ADDR_W-1:0] rem_next;
    logic              rd_pending, pend_next;
    logic [DATA_W-1:0] data_buf, buf_next;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        src_next   = src_ptr;
        dst_next   = dst_ptr;
        rem_next   = remaining;
        pend_next  = rd_pending;
        buf_next   = data_buf;
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_di     = '0;

        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    src_next   = cmd_src;
                    dst_next   = cmd_dst;
                    rem_next   = cmd_len;
                    state_next = (cmd_len == '0) ? DONE : READ;
                end
            end
            READ: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = src_ptr;
                if (mem_gnt) begin
                    src_next   = src_ptr + 1'b1;
                    pend_next  = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = dst_ptr;
                // mem_do is only guaranteed the cycle after the read; capture it so stalls keep the word.
                mem_di   = rd_pending ? mem_do : data_buf;
                if (rd_pending) begin
                    buf_next  = mem_do;
                    pend_next = 1'b0;
                end
                if (mem_gnt) begin
                    dst_next   = dst_ptr + 1'b1;
                    rem_next   = remaining - 1'b1;
                    state_next = (remaining == ADDR_W'(1)) ? DONE : READ;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            remaining  <= '0;
            rd_pending <= 1'b0;
            data_buf   <= '0;
        end else begin
            state      <= state_next;
            src_ptr    <= src_next;
            dst_ptr    <= dst_next;
            remaining  <= rem_next;
            rd_pending <= pend_next;
            data_buf   <= buf_next;
        end
    end

endmodule

// File: tb/tb_sp_dma_engine.sv
// Scoreboard bench for sp_dma_engine: a behavioural SRAM answers granted accesses,
// expected reads/writes/done cycles are queued at issue and popped by a monitor.
module tb_sp_dma_engine;
    import sp_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [AW-1:0] rem;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_src, cmd_dst, cmd_len;
    logic          busy, done;
    logic [AW-1:0] remaining;
    logic          mem_req;
    logic          mem_gnt = 1'b1;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_di;
    logic [DW-1:0] mem_do = '0;

    int checks = 0;
    int fails  = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int req_count = 0;
    bit done_seen = 1'b0;
    bit gnt_toggle = 1'b0;
    logic [3:0] gnt_pat = 4'b1001;

    logic [DW-1:0] sram [0:65535];
    wr_t           wr_q[$];
    logic [AW-1:0] rd_q[$];
    int            done_q[$];

    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic          prev_we;
    logic [DW-1:0] prev_di;

    sp_dma_engine dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_di    (mem_di),
        .mem_do    (mem_do)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port SRAM: read data appears the cycle after a granted read and holds otherwise.
    always @(posedge clk) begin
        if (mem_req && mem_gnt) begin
            if (mem_we) sram[mem_addr] <= mem_di;
            else        mem_do <= sram[mem_addr];
        end
    end

    always @(negedge clk) begin
        int k;
        k = cyc - accept_cyc - 1;
        if (!gnt_toggle || k < 0) mem_gnt = 1'b1;
        else                      mem_gnt = gnt_pat[k % 4];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        wr_t w;
        #2;
        if (mem_req) req_count++;
        if (prev_stall) begin
            check("stall_addr", 64'(mem_addr), 64'(prev_addr));
            check("stall_we", 64'(mem_we), 64'(prev_we));
            check("stall_di", 64'(mem_di), 64'(prev_di));
        end
        prev_stall = mem_req && !mem_gnt;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_di    = mem_di;

        if (mem_req && mem_gnt && mem_we) begin
            if (wr_q.size() == 0) check("unexpected_write", 64'(wr_q.size()), 64'd1);
            else begin
                w = wr_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(w.addr));
                check("wr_data", 64'(mem_di), 64'(w.data));
                check("wr_remaining", 64'(remaining), 64'(w.rem));
                check("wr_busy", 64'(busy), 64'd1);
            end
        end
        if (mem_req && mem_gnt && !mem_we) begin
            if (rd_q.size() == 0) check("unexpected_read", 64'(rd_q.size()), 64'd1);
            else check("rd_addr", 64'(mem_addr), 64'(rd_q.pop_front()));
        end
        if (done) begin
            done_seen = 1'b1;
            if (done_q.size() == 0) check("unexpected_done", 64'(done_q.size()), 64'd1);
            else begin
                check("done_cycle", 64'(cyc - accept_cyc), 64'(done_q.pop_front()));
                check("done_remaining", 64'(remaining), 64'd0);
                check("done_busy", 64'(busy), 64'd0);
            end
        end
    end

    task automatic issue(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic [AW-1:0] len);
        @(negedge clk);
        #3;
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid  = 1'b1;
        cmd_src    = src;
        cmd_dst    = dst;
        cmd_len    = len;
        accept_cyc = cyc;
        done_seen  = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("done_timeout", 64'(done_seen), 64'd1);
        @(negedge clk);
        #3;
        check("ready_after_done", 64'(cmd_ready), 64'd1);
    endtask

    task automatic push_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                             input logic [DW-1:0] d2, input logic [DW-1:0] d3, input int n);
        logic [DW-1:0] d [4];
        d = '{d0, d1, d2, d3};
        for (int i = 0; i < n; i++) begin
            rd_q.push_back(src + AW'(i));
            wr_q.push_back('{addr: dst + AW'(i), data: d[i], rem: AW'(n - i)});
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_remaining"}, 64'(remaining), 64'd0);
        check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_di"}, 64'(mem_di), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
        for (int i = 0; i < 4; i++) begin
            sram[16'h0010 + i] = 32'hA0 + i;
            sram[16'h0060 + i] = 32'hC0 + i;
            sram[16'h0070 + i] = 32'hDEAD;
        end
        sram[16'hFFFE] = 32'hB0; sram[16'hFFFF] = 32'hB1;
        sram[16'h0000] = 32'hB2; sram[16'h0001] = 32'hB3;
        sram[16'h0040] = 32'h5;  sram[16'h0041] = 32'h11;
        sram[16'h0042] = 32'h22; sram[16'h0043] = 32'h33;
        sram[16'h0300] = 32'h1234;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #3;
        check_reset_values("reset");

        // Full-grant copy with an ignored command mid-flight.
        push_copy(16'h0010, 16'h0100, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4);
        done_q.push_back(9);
        issue(16'h0010, 16'h0100, 16'd4);
        repeat (2) @(negedge clk);
        cmd_valid = 1'b1; cmd_src = 16'h0200; cmd_dst = 16'h0300; cmd_len = 16'd2;
        #3;
        check("ignored_cmd_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(30);
        for (int i = 0; i < 4; i++) check("copy1_sram", 64'(sram[16'h0100 + i]), 64'(32'hA0 + i));

        // Zero-length command.
        r0 = req_count;
        done_q.push_back(1);
        issue(16'h0010, 16'h0300, 16'd0);
        wait_done(10);
        check("len0_no_req", 64'(req_count), 64'(r0));
        check("len0_sram", 64'(sram[16'h0300]), 64'h1234);

        // Grant pattern 1,0,0,1: four cycles per word.
        gnt_toggle = 1'b1;
        push_copy(16'h0010, 16'h0140, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4);
        done_q.push_back(17);
        issue(16'h0010, 16'h0140, 16'd4);
        wait_done(40);
        gnt_toggle = 1'b0;

        // Source address wraps past 0xFFFF.
        push_copy(16'hFFFE, 16'h0020, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 4);
        done_q.push_back(9);
        issue(16'hFFFE, 16'h0020, 16'd4);
        wait_done(30);

        // Overlapping ranges replicate the first source word.
        push_copy(16'h0040, 16'h0041, 32'h5, 32'h5, 32'h5, 32'h0, 3);
        done_q.push_back(7);
        issue(16'h0040, 16'h0041, 16'd3);
        wait_done(30);
        check("overlap_sram_43", 64'(sram[16'h0043]), 64'h5);

        // Reset after the second write aborts the copy without done.
        rd_q.push_back(16'h0060); rd_q.push_back(16'h0061); rd_q.push_back(16'h0062);
        wr_q.push_back('{addr: 16'h0070, data: 32'hC0, rem: 16'd4});
        wr_q.push_back('{addr: 16'h0071, data: 32'hC1, rem: 16'd3});
        issue(16'h0060, 16'h0070, 16'd4);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #3;
        check_reset_values("abort");
        repeat (4) @(negedge clk);
        check("abort_no_done", 64'(done_seen), 64'd0);
        check("abort_sram_72", 64'(sram[16'h0072]), 64'hDEAD);
        check("abort_sram_73", 64'(sram[16'h0073]), 64'hDEAD);

        check("wr_q_drained", 64'(wr_q.size()), 64'd0);
        check("rd_q_drained", 64'(rd_q.size()), 64'd0);
        check("done_q_drained", 64'(done_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
